// File: rtl/multicast_receiver.sv
// rtl/multicast_receiver.sv - PE-side multicast bus receiver: tag match, capture FIFO, PE handshake.
// Optional MC_RX_WILDCARD_EN makes an all-ones bus tag field match any own tag.
module multicast_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_TAG_W  = 4,
  parameter int COL_TAG_W  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           cfg_en,
  input  logic [ROW_TAG_W-1:0]           cfg_row_id,
  input  logic [COL_TAG_W-1:0]           cfg_col_id,
  input  logic                           bus_valid,
  input  logic [ROW_TAG_W-1:0]           bus_row_tag,
  input  logic [COL_TAG_W-1:0]           bus_col_tag,
  input  logic [DATA_WIDTH-1:0]          bus_data,
  output logic                           bus_ready,
  output logic                           pe_valid,
  output logic [DATA_WIDTH-1:0]          pe_data,
  input  logic                           pe_ready,
  output logic                           locked,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] ST_UNCFG = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]            r_state;
  logic [ROW_TAG_W-1:0]  r_row_id;
  logic [COL_TAG_W-1:0]  r_col_id;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic w_full;
  logic w_empty;
  logic w_row_hit;
  logic w_col_hit;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

`ifdef MC_RX_WILDCARD_EN
  assign w_row_hit = (bus_row_tag == r_row_id) || (&bus_row_tag);
  assign w_col_hit = (bus_col_tag == r_col_id) || (&bus_col_tag);
`else
  assign w_row_hit = (bus_row_tag == r_row_id);
  assign w_col_hit = (bus_col_tag == r_col_id);
`endif

  // Ready depends on registered occupancy only, so every PE on a segment sees the same beat-independent value.
  assign bus_ready  = (r_state == ST_UNCFG) ? 1'b1 : !w_full;
  assign pe_valid   = !w_empty;
  assign pe_data    = r_mem[r_rd_ptr];
  assign locked     = (r_state == ST_RUN);
  assign fifo_count = r_count;

  assign w_push = bus_valid && bus_ready && w_row_hit && w_col_hit && (r_state == ST_RUN) && !cfg_en;
  assign w_pop  = pe_valid && pe_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= ST_UNCFG;
      r_row_id <= '0;
      r_col_id <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (cfg_en) begin
      // Retagging flushes; any same-cycle pop is lost with the flush.
      r_state  <= ST_RUN;
      r_row_id <= cfg_row_id;
      r_col_id <= cfg_col_id;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/multicast_receiver.md
Name: multicast_receiver

Overview:
- PE-side receiving end of the row/column multicast bus.
- Holds the PE's row/column tag, loaded once at array initialisation. Compares every bus beat against that tag and captures only matching beats into a small FIFO.
- Presents captured operands to the PE datapath through a valid/ready handshake.
- One instance per PE; the array controller ANDs all `bus_ready` outputs on a bus segment.

Parameters:
- DATA_WIDTH, 16, width of the multicast data word
- ROW_TAG_W, 4, width of the row tag
- COL_TAG_W, 4, width of the column tag
- FIFO_DEPTH, 4, receive FIFO entries; power of 2, at least 2

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous active-low reset
- cfg_en  input  1  load the tag in this cycle
- cfg_row_id  input  ROW_TAG_W  row tag to load
- cfg_col_id  input  COL_TAG_W  column tag to load
- bus_valid  input  1  multicast beat valid
- bus_row_tag  input  ROW_TAG_W  destination row of the beat
- bus_col_tag  input  COL_TAG_W  destination column of the beat
- bus_data  input  DATA_WIDTH  multicast payload
- bus_ready  output  1  receiver can take a beat
- pe_valid  output  1  FIFO head valid
- pe_data  output  DATA_WIDTH  FIFO head data
- pe_ready  input  1  PE consumes the head
- locked  output  1  tag is loaded; state is RUN
- fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface: one clock `clk`; reset `rstn` is synchronous and active-low, sampled on the rising edge of `clk`.
- Reset values:
  - state=UNCFG, locked=0, pe_valid=0, pe_data=0, fifo_count=0.
  - Stored tags = 0; FIFO pointers = 0.
  - bus_ready=1.
- States:
  - UNCFG: all bus beats are ignored; bus_ready=1 so this PE never stalls the bus.
  - RUN: normal operation.
- State transitions:
  - cfg_en=1 in any state: latch cfg_row_id and cfg_col_id, flush the FIFO (pointers and count to 0), next state RUN.
  - A bus beat arriving in the same cycle as cfg_en is dropped.
  - A pop in the same cycle as cfg_en is discarded with the flush.
  - No other transitions; only reset returns the block to UNCFG.
- Match: `hit = (bus_row_tag == row_id) && (bus_col_tag == col_id)`.
- bus_ready in RUN = !full.
  - The value is independent of the tag, so the bus-level AND is the same for every beat.
  - The combinational path runs from registered state only; there is no path from the bus_* inputs.
- Push: bus_valid && bus_ready && hit && state==RUN && !cfg_en.
  - A beat that is accepted on the bus (bus_valid && bus_ready) with no hit is consumed and discarded.
- Pop: pe_valid && pe_ready.
- pe_valid = !empty; pe_data = FIFO head, read from a register (no read-through).
- Latency: a beat pushed in cycle N gives pe_valid=1 with its data in cycle N+1.
- Simultaneous push and pop:
  - When not full and not empty, fifo_count is unchanged and data ordering is preserved.
  - When empty, the push still lands; pe_valid rises in the next cycle. There is no bypass.
  - When full, bus_ready=0, so no push; the pop frees one slot and bus_ready=1 in the next cycle.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from fifo_count, which never exceeds FIFO_DEPTH.
- A reset asserted mid-stream discards FIFO contents and tags and returns the block to UNCFG in the next cycle.

Optional Feature:
- Macro: MC_RX_WILDCARD_EN.
- Defined: a tag field of all-ones on the bus is a wildcard.
  - bus_row_tag all-ones matches any row, giving a column multicast; bus_col_tag all-ones matches any column.
  - Both fields all-ones is a full-array broadcast.
  - The all-ones value stays loadable as an own-ID but then cannot be addressed exclusively.
- Undefined: exact equality only; all-ones is an ordinary tag value.

Test Plan:
- Reset, then cfg_en with row=2, col=1. Send 3 beats tagged (2,1) with data 0x0011, 0x0022, 0x0033, pe_ready=1 -> locked=1; pe_data shows 0x0011, 0x0022, 0x0033 in order, each one cycle after its push; fifo_count peaks at 1.
- Configured (2,1): send beats tagged (2,0) and (3,1) -> bus_ready stays 1, pe_valid stays 0, fifo_count=0.
- pe_ready=0: push 4 matching beats 0xA000..0xA003 -> fifo_count=4 and bus_ready=0; a 5th beat 0xA004 is held on the bus. Pulse pe_ready for 1 cycle -> 0xA000 popped, bus_ready=1 in the next cycle, 0xA004 accepted; drain order is A001, A002, A003, A004.
- Before cfg_en, send a beat tagged (0,0) -> not captured, bus_ready=1, locked=0. Then with 2 entries queued, assert cfg_en with (5,5) -> fifo_count=0, pe_valid=0 in the next cycle.
- Push and pop in the same cycle with fifo_count=2 -> count stays 2, no data lost. Assert rstn=0 mid-stream -> next cycle locked=0, fifo_count=0, pe_valid=0.
- MC_RX_WILDCARD_EN defined, configured (2,1): beats tagged (15,1) and (15,15) are captured, beat tagged (15,2) is dropped. Without the macro, all three are dropped.
